delta_accum_engine: RTL
=======================

DELTA_ACCUM_ENGINE -- requirements
Module: delta_accum_engine

Interface
REQ-001 SHALL have parameter IDX_W, default 4, index width; DEPTH = 2**IDX_W entries.
REQ-002 SHALL have parameter DATA_W, default 4, unsigned load-data width.
REQ-003 SHALL have parameter MEM_W, default DATA_W+2, signed entry width.
REQ-004 SHALL have parameters CNT_W, default 8, and ACC_W, default 10, which set the count and total accumulator widths; RES_W = ACC_W+2.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port mode  in  2  00 MIN, 01 MAX, 10 MADD, 11 COUNT.
REQ-008 SHALL have port load  in  1  write request to entry index.
REQ-009 SHALL have ports index  in  IDX_W and data  in  DATA_W, carrying the load address and load value.
REQ-010 SHALL have port start  in  1  begin a scan in the current mode.
REQ-011 SHALL have port clr  in  1  zero every memory entry.
REQ-012 SHALL have ports busy  out  1 (CLEAR or SCAN), done  out  1 (one-cycle completion pulse), found  out  1 (MIN/MAX hit) and result  out  RES_W.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, SCAN, DONE: IDLE->CLEAR on clr; IDLE->SCAN on start; CLEAR->IDLE after entry DEPTH-1 is zeroed; SCAN->DONE on termination; DONE->IDLE unconditionally.
REQ-014 SHALL accept clr, start and load only in IDLE, with priority clr > start > load; all three SHALL be ignored in the other states.
REQ-015 SHALL latch mode on start acceptance; mode changes during SCAN SHALL have no effect.
REQ-016 SHALL, on a load with mode != MADD, write entry[index] to 1.
REQ-017 SHALL, on a load with mode MADD, set entry[index] += data and entry[index-1] -= data, with data zero-extended; when index = 0, the subtraction SHALL be dropped (no wrap).
REQ-018 SHALL perform entry arithmetic modulo 2**MEM_W.
REQ-019 SHALL make CLEAR zero one entry per cycle, ascending from 0, so busy stays high for exactly DEPTH cycles.
REQ-020 SHALL, in MIN, scan ascending from 0, one entry per cycle; the first nonzero entry k SHALL terminate the scan with result = k and found = 1, and DONE SHALL follow k+1 edges after the start edge.
REQ-021 SHALL, in MAX, scan descending from DEPTH-1 with the same termination rules as MIN.
REQ-022 SHALL, when MIN or MAX finds no nonzero entry after DEPTH entries, produce found = 0 and result = 0.
REQ-023 SHALL, in MADD, scan descending over all DEPTH entries, each cycle updating delta += entry[i], count += old delta and total += old count, all simultaneously.
REQ-024 SHALL, at MADD termination, set result = total + count, zero-extended to RES_W.
REQ-025 SHALL, in COUNT, scan all DEPTH entries with result = the number of nonzero entries.
REQ-026 SHALL clear delta, count and total on start acceptance.
REQ-027 SHALL hold delta signed at MEM_W+IDX_W bits; count and total SHALL wrap modulo their widths unless REQ-033 applies.
REQ-028 SHALL assert done for exactly one cycle (state DONE); result and found SHALL update at DONE entry and hold until the next DONE or reset.
REQ-029 SHALL accept a start asserted in the same cycle as done only after the following IDLE cycle.

Reset
REQ-030 SHALL, on rst_n low, immediately force state IDLE and busy=0, done=0, found=0, result=0, with i, delta, count and total all 0.
REQ-031 SHALL, on reset during CLEAR or SCAN, abort the operation with no done pulse.
REQ-032 SHALL leave memory contents unaffected by reset; only clr SHALL zero memory.

Configuration
REQ-033 SHALL, with DELTA_ACCUM_SAT_EN defined, saturate count to [0, 2**CNT_W-1] and total to 2**ACC_W-1 instead of wrapping; without it, both SHALL wrap silently.

Verification
REQ-034 SHALL cover: reset, clr, wait DEPTH cycles, MIN start -> done after 16 scan cycles, found=0, result=0.
REQ-035 SHALL cover: clr, load indices 9 and 3 (mode MIN), MIN start -> found=1, result=3, done 4 edges after start; MAX start -> result=9.
REQ-036 SHALL cover: clr, MADD load index 5 data 3, MADD start -> result=15 (count=3, total=12) after 16 scan cycles.
REQ-037 SHALL cover: MADD load index 0 data 7 -> entry[0]=7 and entry[15] unchanged.
REQ-038 SHALL cover: clr, COUNT-mode loads at indices 1, 4, 4, 15, COUNT start -> result=3; start and load asserted together in IDLE -> load ignored.
REQ-039 SHALL cover: rst_n low mid-SCAN -> outputs 0, no done; memory preserved, verified by a rescan returning the prior result.

Source files
------------

// File: rtl/delta_accum_engine.sv
// Entry memory with MIN/MAX/COUNT scans and a descending second-order
// accumulation (MADD). Define DELTA_ACCUM_SAT_EN to saturate count/total.
module delta_accum_engine #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 4,
  parameter int MEM_W  = DATA_W + 2,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ACC_W+1:0]  result
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int DW    = MEM_W + IDX_W;
  localparam int RES_W = ACC_W + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] M_MIN   = 2'd0;
  localparam logic [1:0] M_MAX   = 2'd1;
  localparam logic [1:0] M_MADD  = 2'd2;
  localparam logic [1:0] M_COUNT = 2'd3;

  logic [MEM_W-1:0]        mem [DEPTH];
  logic [1:0]              state;
  logic [1:0]              mode_q;
  logic [IDX_W-1:0]        i;
  logic signed [DW-1:0]    delta;
  logic [CNT_W-1:0]        count;
  logic [ACC_W-1:0]        total;
  logic [IDX_W:0]          nz;

  logic [MEM_W-1:0]        cur;
  logic                    hit;
  logic                    last;
  logic signed [DW-1:0]    delta_nxt;
  logic [CNT_W-1:0]        count_nxt;
  logic [ACC_W-1:0]        total_nxt;
  logic [IDX_W:0]          nz_nxt;
  logic [RES_W-1:0]        madd_res;

`ifdef DELTA_ACCUM_SAT_EN
  localparam int CW = ((CNT_W > DW) ? CNT_W : DW) + 2;
  logic signed [CW-1:0]    csum;
  logic [ACC_W:0]          tsum;
`endif

  assign busy = (state == S_CLEAR) || (state == S_SCAN);
  assign done = (state == S_DONE);

  always_comb begin
    cur       = mem[i];
    hit       = (cur != '0);
    last      = (mode_q == M_MIN) ? (i == IDX_W'(DEPTH - 1)) : (i == '0);
    delta_nxt = delta + {{IDX_W{cur[MEM_W-1]}}, cur};
`ifdef DELTA_ACCUM_SAT_EN
    // count is unsigned but absorbs a signed delta: clamp both ends
    csum      = CW'($signed({1'b0, count})) + CW'(delta);
    count_nxt = csum[CW-1] ? '0 : ((|csum[CW-2:CNT_W]) ? '1 : csum[CNT_W-1:0]);
    tsum      = {1'b0, total} + (ACC_W + 1)'(count);
    total_nxt = tsum[ACC_W] ? '1 : tsum[ACC_W-1:0];
`else
    count_nxt = count + CNT_W'(delta);
    total_nxt = total + ACC_W'(count);
`endif
    nz_nxt    = nz + (IDX_W + 1)'(hit);
    madd_res  = RES_W'(total_nxt) + RES_W'(count_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mode_q <= M_MIN;
      i      <= '0;
      delta  <= '0;
      count  <= '0;
      total  <= '0;
      nz     <= '0;
      found  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr) begin
            state <= S_CLEAR;
            i     <= '0;
          end else if (start) begin
            state  <= S_SCAN;
            mode_q <= mode;
            i      <= (mode == M_MIN) ? '0 : IDX_W'(DEPTH - 1);
            delta  <= '0;
            count  <= '0;
            total  <= '0;
            nz     <= '0;
          end
        end
        S_CLEAR: begin
          if (i == IDX_W'(DEPTH - 1)) begin
            state <= S_IDLE;
            i     <= '0;
          end else begin
            i <= i + IDX_W'(1);
          end
        end
        S_SCAN: begin
          i <= (mode_q == M_MIN) ? i + IDX_W'(1) : i - IDX_W'(1);
          case (mode_q)
            M_MADD: begin
              delta <= delta_nxt;
              count <= count_nxt;
              total <= total_nxt;
            end
            M_COUNT: nz <= nz_nxt;
            default: ;
          endcase
          if (last || (((mode_q == M_MIN) || (mode_q == M_MAX)) && hit)) begin
            state <= S_DONE;
            case (mode_q)
              M_MIN, M_MAX: begin
                found  <= hit;
                result <= hit ? RES_W'(i) : '0;
              end
              M_MADD: begin
                found  <= 1'b0;
                result <= madd_res;
              end
              default: begin
                found  <= 1'b0;
                result <= RES_W'(nz_nxt);
              end
            endcase
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory survives reset; only CLEAR or an accepted load writes it
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[i] <= '0;
    end else if ((state == S_IDLE) && !clr && !start && load) begin
      if (mode == M_MADD) begin
        mem[index] <= mem[index] + MEM_W'(data);
        if (index != '0)
          mem[index - IDX_W'(1)] <= mem[index - IDX_W'(1)] - MEM_W'(data);
      end else begin
        mem[index] <= MEM_W'(1);
      end
    end
  end

endmodule
